scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Generates the 3-bit select code that drives the 3-to-8 line decoder: sel[2] feeds input a, sel[1] feeds b, sel[0] feeds c.
- Steps the code at a programmable rate, counting up, down, ping-pong or holding.
- Flags every advance and every end-of-sweep so downstream logic (LED/digit scan, row strobe) stays aligned with the active decoder output.

Parameters:
- PRESCALE, 4: enabled clock cycles per step. Legal range 1..65535.
- PS_W, 16: prescaler counter width. Must hold PRESCALE-1.
- MAX_CODE, 7: highest code in the sweep. Legal range 1..7; codes above it are never driven.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advances the prescaler when high; prescaler and sel hold when low
- mode  in  2  00 up, 01 down, 10 ping-pong, 11 hold
- load  in  1  one-cycle request: sel takes load_val
- load_val  in  3  value to load
- sel  out  3  registered select code to the decoder
- step  out  1  one-cycle pulse, high in the same cycle sel shows its new value
- wrap  out  1  one-cycle pulse, high with step when a sweep ends

Behaviour:
- Reset, asynchronous on rst_n low:
  - sel=0, prescaler=0, dir=up, step=0, wrap=0.
  - Deassertion is synchronous to clk; the first prescaler increment is on the first edge after release with en=1.
- Prescaler:
  - When en=1, counts 0..PRESCALE-1 and returns to 0.
  - tick=1 in the cycle where count==PRESCALE-1 and en=1.
  - PRESCALE=1 gives tick on every enabled cycle.
  - When en=0, the count freezes and tick=0.
- On a tick with load=0, the next sel depends on mode:
  - up: sel+1; MAX_CODE->0 with wrap.
  - down: sel-1; 0->MAX_CODE with wrap.
  - ping-pong: moves in dir. At MAX_CODE with dir=up: dir<=down, sel<=MAX_CODE-1, wrap. At 0 with dir=down: dir<=up, sel<=1, wrap. Endpoints are visited once per turn, never repeated.
  - hold: sel unchanged, step=0, wrap=0. The prescaler keeps running.
- dir register:
  - In up mode, dir<=up every cycle.
  - In down mode, dir<=down every cycle.
  - In ping-pong and hold, dir is retained. Entering ping-pong therefore continues the previous direction.
- Latency: sel, step and wrap are all registered. They change on the clock edge ending the tick cycle, so step/wrap are high for exactly the first cycle of the new sel value.
- load has priority over tick and over en:
  - sel<=load_val, or MAX_CODE if load_val>MAX_CODE.
  - Prescaler is cleared to 0; step=0 and wrap=0 that cycle.
  - In ping-pong, dir is set to up, unless the loaded value equals MAX_CODE, in which case dir is set to down.
- Mode changes take effect on the next tick; no state is disturbed.
- If sel somehow exceeds MAX_CODE, the next tick forces sel=0 and dir=up. This state is unreachable in normal use.
- Reset mid-sweep drops sel to 0 immediately and clears any pending pulse.

Decomposition:
- Package scan_pkg holds:
  - SEL_W=3
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11
  - DIR_UP / DIR_DOWN constants
- Sub-module tick_gen holds the prescaler and tick output:
  - parameters PRESCALE, PS_W
  - ports clk, rst_n, en, clr, tick
- scan_sequencer holds the code, dir and pulse registers.

Test Plan:
- Reset, PRESCALE=4, mode=up, en=1 for 40 cycles -> sel steps 0,1..7,0 every 4 cycles; step is high 1 cycle per change; wrap is high only on 7->0.
- mode=down, PRESCALE=1, en=1, starting from sel=0 -> first step gives sel=7 with wrap=1; then 6,5,... on consecutive cycles.
- mode=ping-pong, MAX_CODE=5, PRESCALE=1, from reset -> sequence 0,1,2,3,4,5,4,3,2,1,0,1; wrap is high on entering 4 (after 5) and on entering 1 (after 0).
- Toggle en low for 10 cycles when prescaler=2 -> sel and count freeze; after en returns, the next step is 2 enabled cycles later.
- load=1 with load_val=6, MAX_CODE=5, coincident with a tick -> sel=5, step=0, prescaler restarts at 0; the next step comes PRESCALE cycles later.
- Assert rst_n low asynchronously mid-cycle while sel=3 -> sel=0 and step=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants for the decoder scan sequencer: code width, mode encodings,
// sweep direction and a range clamp used when loading a code.
package scan_pkg;

    localparam int SEL_W = 3;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Compared one bit wider so the test stays meaningful even when max_code is the full range.
    function automatic logic [SEL_W-1:0] clamp_code(input logic [SEL_W-1:0] v, input int max_code);
        return ({1'b0, v} > (SEL_W+1)'(max_code)) ? SEL_W'(max_code) : v;
    endfunction

endpackage

// File: rtl/scan_sequencer_tick_gen.sv
// Enable-gated prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// clr restarts the count at 0 and wins over en.
module tick_gen
#(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] count_q;
    logic [PS_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q >= LAST) begin
                tick    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Drives the 3-to-8 decoder select code, stepping up, down, ping-pong or holding
// at the prescaled rate, with step/wrap pulses aligned to the first cycle of each new code.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16,
    parameter int MAX_CODE = 7
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel,
    output logic             step,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] MAX = SEL_W'(MAX_CODE);

    logic             tick;
    logic [SEL_W-1:0] sel_q, sel_d;
    dir_e             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             out_of_range;

    tick_gen #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign out_of_range = ({1'b0, sel_q} > (SEL_W+1)'(MAX_CODE));

    always_comb begin
        sel_d  = sel_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;

        // Fixed-direction modes pin dir every cycle; ping-pong and hold keep it.
        if (mode == MODE_UP) begin
            dir_d = DIR_UP;
        end else if (mode == MODE_DOWN) begin
            dir_d = DIR_DOWN;
        end

        if (load) begin
            sel_d = clamp_code(load_val, MAX_CODE);
            if (mode == MODE_PINGPONG) begin
                dir_d = (sel_d == MAX) ? DIR_DOWN : DIR_UP;
            end
        end else if (tick) begin
            if (out_of_range) begin
                sel_d  = '0;
                dir_d  = DIR_UP;
                step_d = 1'b1;
            end else begin
                case (mode)
                    MODE_UP: begin
                        step_d = 1'b1;
                        if (sel_q == MAX) begin
                            sel_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                    MODE_DOWN: begin
                        step_d = 1'b1;
                        if (sel_q == '0) begin
                            sel_d  = MAX;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q - SEL_W'(1);
                        end
                    end
                    MODE_PINGPONG: begin
                        step_d = 1'b1;
                        // Turn at the endpoints so neither end is shown twice in a row.
                        if (dir_q == DIR_UP) begin
                            if (sel_q == MAX) begin
                                dir_d  = DIR_DOWN;
                                sel_d  = MAX - SEL_W'(1);
                                wrap_d = 1'b1;
                            end else begin
                                sel_d = sel_q + SEL_W'(1);
                            end
                        end else begin
                            if (sel_q == '0) begin
                                dir_d  = DIR_UP;
                                sel_d  = SEL_W'(1);
                                wrap_d = 1'b1;
                            end else begin
                                sel_d = sel_q - SEL_W'(1);
                            end
                        end
                    end
                    default: begin
                        sel_d = sel_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign sel  = sel_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: three configurations share the stimulus, and a
// step-triggered monitor checks {cycle, sel, wrap} of the active one against a queue.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int W = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic [1:0] mode     = MODE_UP;
    logic       load     = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] sel_a, sel_b, sel_c;
    logic       step_a, step_b, step_c;
    logic       wrap_a, wrap_b, wrap_c;

    // u_a: slow up sweep with MAX 5; u_b: full-range down at PRESCALE 1; u_c: ping-pong MAX 5.
    scan_sequencer #(.PRESCALE(4), .PS_W(16), .MAX_CODE(5)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .sel(sel_a), .step(step_a), .wrap(wrap_a)
    );
    scan_sequencer #(.PRESCALE(1), .PS_W(16), .MAX_CODE(7)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .sel(sel_b), .step(step_b), .wrap(wrap_b)
    );
    scan_sequencer #(.PRESCALE(1), .PS_W(16), .MAX_CODE(5)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .sel(sel_c), .step(step_c), .wrap(wrap_c)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cur    = 0;
    int c0     = 0;
    int n_vec  = 0;
    int n_err  = 0;

    logic [W-1:0] exp_q[$];

    logic [2:0] mon_sel;
    logic       mon_step;
    logic       mon_wrap;

    assign mon_sel  = (cur == 0) ? sel_a  : (cur == 1) ? sel_b  : sel_c;
    assign mon_step = (cur == 0) ? step_a : (cur == 1) ? step_b : step_c;
    assign mon_wrap = (cur == 0) ? wrap_a : (cur == 1) ? wrap_b : wrap_c;

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;

    always @(negedge clk) begin
        if (mon_step) begin
            n_vec++;
            mon_got = {16'(cyc - c0), mon_sel, mon_wrap};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_step dut=%0d: got cyc=%0d sel=%0d wrap=%0b, no step required",
                         cur, cyc - c0, mon_sel, mon_wrap);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL step_tuple dut=%0d: got cyc=%0d sel=%0d wrap=%0b, required cyc=%0d sel=%0d wrap=%0b",
                             cur, mon_got[19:4], mon_got[3:1], mon_got[0],
                             mon_exp[19:4], mon_exp[3:1], mon_exp[0]);
                end
            end
        end else if (mon_wrap) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_without_step dut=%0d: got wrap=1 at cyc=%0d, required 0", cur, cyc - c0);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic push_exp(input int stamp, input int s, input bit w);
        exp_q.push_back({16'(stamp), 3'(s), w});
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_to(input int t);
        while ((cyc - c0) < t) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        check("reset_sel_a", int'(sel_a), 0);
        check("reset_step_a", int'(step_a), 0);
        check("reset_wrap_a", int'(wrap_a), 0);
        check("reset_sel_c", int'(sel_c), 0);

        // Phase A: up sweep 0..5, en freeze, clamped load on a tick, async reset at sel=3.
        cur = 0; mode = MODE_UP; en = 1'b1; rst_n = 1'b1; c0 = cyc;
        push_exp(4, 1, 0);  push_exp(8, 2, 0);  push_exp(12, 3, 0);
        push_exp(16, 4, 0); push_exp(20, 5, 0); push_exp(24, 0, 1);
        push_exp(28, 1, 0);
        wait_to(30); en = 1'b0;
        wait_to(35); check("freeze_sel", int'(sel_a), 1);
        wait_to(40); en = 1'b1;
        push_exp(42, 2, 0);
        wait_to(45); load = 1'b1; load_val = 3'd6;
        wait_to(46); load = 1'b0;
        check("load_clamp_sel", int'(sel_a), 5);
        check("load_no_step", int'(step_a), 0);
        push_exp(50, 0, 1); push_exp(54, 1, 0); push_exp(58, 2, 0); push_exp(62, 3, 0);
        wait_to(62);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_sel", int'(sel_a), 0);
        check("async_reset_step", int'(step_a), 0);
        @(negedge clk);
        check("queue_empty_a", exp_q.size(), 0);

        // Phase B: down from 0 at PRESCALE=1, MAX 7.
        cur = 1; mode = MODE_DOWN; en = 1'b1; rst_n = 1'b1; c0 = cyc;
        push_exp(1, 7, 1); push_exp(2, 6, 0); push_exp(3, 5, 0);
        push_exp(4, 4, 0); push_exp(5, 3, 0); push_exp(6, 2, 0);
        push_exp(7, 1, 0); push_exp(8, 0, 0); push_exp(9, 7, 1);
        wait_to(9);
        #1 rst_n = 1'b0; en = 1'b0;
        @(negedge clk);
        check("queue_empty_b", exp_q.size(), 0);

        // Phase C: ping-pong MAX 5, then hold, then load of MAX in ping-pong turns downward.
        cur = 2; mode = MODE_PINGPONG; en = 1'b1; rst_n = 1'b1; c0 = cyc;
        push_exp(1, 1, 0);  push_exp(2, 2, 0);  push_exp(3, 3, 0);
        push_exp(4, 4, 0);  push_exp(5, 5, 0);  push_exp(6, 4, 1);
        push_exp(7, 3, 0);  push_exp(8, 2, 0);  push_exp(9, 1, 0);
        push_exp(10, 0, 0); push_exp(11, 1, 1); push_exp(12, 2, 0);
        wait_to(12); mode = MODE_HOLD;
        wait_to(14); check("hold_sel", int'(sel_c), 2);
        wait_to(15); mode = MODE_PINGPONG; load = 1'b1; load_val = 3'd5;
        wait_to(16); load = 1'b0;
        check("pp_load_sel", int'(sel_c), 5);
        check("pp_load_no_step", int'(step_c), 0);
        push_exp(17, 4, 0); push_exp(18, 3, 0);
        wait_to(18);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("queue_empty_c", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
